wb_arbiter: RTL
===============

WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have parameter DEPTH, default 2, meaning the number of entries in the vector-side write buffer (legal 1..8).
REQ-002 SHALL have parameter STARVE_MAX, default 8, meaning the cycles a buffer head may wait before a forced drain.
REQ-003 SHALL have port clk  input  1  meaning the sole clock; all state updates on posedge clk.
REQ-004 SHALL have port rst  input  1  meaning reset, synchronous and active-high.
REQ-005 SHALL have ports s_valid/s_wbr/s_data  input  1/5/36  meaning the scalar pipeline register-write request, target and data.
REQ-006 SHALL have ports v_valid/v_wbr/v_data  input  1/5/36  meaning the vector pipeline scalar-register write request, target and data.
REQ-007 SHALL have port s_stall  output  1  meaning the scalar writeback must hold its request this cycle.
REQ-008 SHALL have port v_stall  output  1  meaning the vector writeback must hold its request this cycle.
REQ-009 SHALL have ports rf_we/rf_wbr/rf_data  output  1/5/36  meaning the registered scalar register-file write port.
REQ-010 SHALL have ports chk_reg/chk_hit  input 5/output 1  meaning a decode query: a write to chk_reg is pending inside the arbiter.

Function
REQ-011 SHALL drive rf_we/rf_wbr/rf_data from a register, giving 1-cycle latency from the accepted request to the register-file write.
REQ-012 SHALL accept at most one write per cycle to the output register.
REQ-013 SHALL operate as FSM IDLE (buffer empty), PEND (buffer non-empty) and FORCE (forced drain).
REQ-014 In IDLE, SHALL grant s_valid with priority; if v_valid is also high, the vector request SHALL be enqueued; a lone v_valid SHALL be granted directly.
REQ-015 In PEND with s_valid high, SHALL grant the scalar request; any v_valid SHALL be enqueued behind the existing entries.
REQ-016 In PEND with s_valid low, SHALL grant the buffer head (oldest first); a simultaneous v_valid SHALL be enqueued at the tail, never bypassing.
REQ-017 SHALL transition PEND->IDLE when the last entry is dequeued and no enqueue occurs in the same cycle.
REQ-018 SHALL count the cycles the head entry has waited, cleared on every dequeue and on entry into PEND.
REQ-019 SHALL transition PEND->FORCE when the count reaches STARVE_MAX; in FORCE it SHALL assert s_stall and grant the head for exactly one cycle, then return to PEND or IDLE.
REQ-020 SHALL assert v_stall combinationally whenever buffer occupancy equals DEPTH; a stalled v_valid SHALL NOT be enqueued.
REQ-021 SHALL allow a full buffer to dequeue and lower v_stall in the following cycle, never in the same cycle.
REQ-022 SHALL assert chk_hit when chk_reg matches any valid buffer entry or the output register with rf_we=1.
REQ-023 SHALL treat writes to register 0 as normal requests; it performs no filtering.
REQ-024 SHALL preserve per-requester program order; scalar versus vector order is defined solely by the grants above.

Reset
REQ-025 On rst high at posedge clk, SHALL set rf_we=0, rf_wbr=0, rf_data=0, occupancy=0, age=0 and state=IDLE.
REQ-026 During reset, SHALL hold s_stall=0, v_stall=0 and chk_hit=0.
REQ-027 SHALL discard buffered entries on reset mid-operation without writing them.

Configuration
REQ-028 With macro WB_ARB_STARVE_EN defined, SHALL implement the age counter and the FORCE state per REQ-018/019.
REQ-029 Without WB_ARB_STARVE_EN, SHALL omit the age counter and FORCE, and tie s_stall to 0; the buffer then drains only when s_valid is low.

Verification
REQ-030 s_valid=1 (r3, 0x5) and v_valid=1 (r4, 0x9) in the same cycle -> next cycle rf r3=0x5; the following idle cycle rf r4=0x9.
REQ-031 DEPTH=2, s_valid held high, v_valid on 3 consecutive cycles -> v_stall=1 on the third cycle, and exactly 2 entries are later written in order.
REQ-032 WB_ARB_STARVE_EN, STARVE_MAX=8, s_valid held high, one vector entry buffered -> s_stall=1 for exactly 1 cycle after 8 waiting cycles, and the entry is written the next cycle.
REQ-033 Entry r7 buffered, chk_reg=7 -> chk_hit=1 until the cycle after the r7 write; chk_reg=8 -> chk_hit=0.
REQ-034 rst asserted with 2 entries buffered -> the next cycle has rf_we=0, v_stall=0, chk_hit=0, and neither entry is ever written.

Source files
------------

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - scalar/vector register-file writeback arbiter with a vector-side write buffer
// Define WB_ARB_STARVE_EN to build the age counter and FORCE drain state.
module wb_arbiter #(
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        s_valid,
  input  logic [4:0]  s_wbr,
  input  logic [35:0] s_data,
  input  logic        v_valid,
  input  logic [4:0]  v_wbr,
  input  logic [35:0] v_data,
  output logic        s_stall,
  output logic        v_stall,
  output logic        rf_we,
  output logic [4:0]  rf_wbr,
  output logic [35:0] rf_data,
  input  logic [4:0]  chk_reg,
  output logic        chk_hit
);
  localparam int CW = $clog2(DEPTH + 1);

`ifdef WB_ARB_STARVE_EN
  localparam int AW = $clog2(STARVE_MAX + 1);
  typedef enum logic [1:0] {IDLE, PEND, FORCE} state_t;
`else
  typedef enum logic [1:0] {IDLE, PEND} state_t;
  if (STARVE_MAX < 1) begin : g_starve_max_unused
  end
`endif

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [4:0]    buf_wbr_q  [DEPTH];
  logic [4:0]    buf_wbr_d  [DEPTH];
  logic [35:0]   buf_data_q [DEPTH];
  logic [35:0]   buf_data_d [DEPTH];
  logic          rf_we_q, rf_we_d;
  logic [4:0]    rf_wbr_q, rf_wbr_d;
  logic [35:0]   rf_data_q, rf_data_d;
`ifdef WB_ARB_STARVE_EN
  logic [AW-1:0] age_q, age_d;
`endif

  logic          full;
  logic          force_drain;
  logic          take_head, take_s, take_v;
  logic          enq;
  logic [CW-1:0] wr_idx;
  logic          hit;

  assign full = (cnt_q == CW'(DEPTH));

`ifdef WB_ARB_STARVE_EN
  assign force_drain = (state_q == FORCE);
`else
  assign force_drain = 1'b0;
`endif

  // Buffer head wins in FORCE, or in PEND whenever the scalar side is quiet.
  assign take_head = force_drain || (state_q == PEND && !s_valid);
  assign take_s    = !take_head && s_valid;
  assign take_v    = !take_head && !s_valid && v_valid;
  assign enq       = v_valid && !full && !take_v;
  assign wr_idx    = cnt_q - CW'(take_head);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + CW'(enq) - CW'(take_head);
    buf_wbr_d  = buf_wbr_q;
    buf_data_d = buf_data_q;
    rf_we_d    = take_head || take_s || take_v;
    rf_wbr_d   = rf_wbr_q;
    rf_data_d  = rf_data_q;

    if (take_head) begin
      rf_wbr_d  = buf_wbr_q[0];
      rf_data_d = buf_data_q[0];
      for (int i = 0; i < DEPTH - 1; i++) begin
        buf_wbr_d[i]  = buf_wbr_q[i+1];
        buf_data_d[i] = buf_data_q[i+1];
      end
    end else if (take_s) begin
      rf_wbr_d  = s_wbr;
      rf_data_d = s_data;
    end else if (take_v) begin
      rf_wbr_d  = v_wbr;
      rf_data_d = v_data;
    end

    // Tail slot is computed after the shift so a same-cycle enqueue never bypasses.
    for (int i = 0; i < DEPTH; i++) begin
      if (enq && CW'(i) == wr_idx) begin
        buf_wbr_d[i]  = v_wbr;
        buf_data_d[i] = v_data;
      end
    end

    state_d = (cnt_d == '0) ? IDLE : PEND;

`ifdef WB_ARB_STARVE_EN
    if (state_q == IDLE || take_head) age_d = '0;
    else                              age_d = age_q + AW'(1);
    if (state_q == PEND && !take_head && cnt_d != '0 && age_d == AW'(STARVE_MAX))
      state_d = FORCE;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rf_we_q   <= 1'b0;
      rf_wbr_q  <= '0;
      rf_data_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        buf_wbr_q[i]  <= '0;
        buf_data_q[i] <= '0;
      end
`ifdef WB_ARB_STARVE_EN
      age_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rf_we_q    <= rf_we_d;
      rf_wbr_q   <= rf_wbr_d;
      rf_data_q  <= rf_data_d;
      buf_wbr_q  <= buf_wbr_d;
      buf_data_q <= buf_data_d;
`ifdef WB_ARB_STARVE_EN
      age_q      <= age_d;
`endif
    end
  end

  always_comb begin
    hit = rf_we_q && (rf_wbr_q == chk_reg);
    for (int i = 0; i < DEPTH; i++) begin
      if (CW'(i) < cnt_q && buf_wbr_q[i] == chk_reg) hit = 1'b1;
    end
  end

  assign chk_hit = hit && !rst;
  assign v_stall = full && !rst;
  assign s_stall = force_drain && !rst;
  assign rf_we   = rf_we_q;
  assign rf_wbr  = rf_wbr_q;
  assign rf_data = rf_data_q;

endmodule
